// File: rtl/conv1_layer1_dense_accum.sv
// Reduces the 25-lane conv1 product word through a pipelined signed adder tree, then
// accumulates ACC_LEN tree sums into one saturating output-feature value for writeback.
module conv1_layer1_dense_accum #(
   parameter int NUM_LANE = 25,
   parameter int PROD_W   = 32,
   parameter int ACC_W    = 48,
   parameter int ACC_LEN  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [NUM_LANE*PROD_W-1:0] mult_res,
   input  logic                       mult_res_v,
   output logic [ACC_W-1:0]           acc_res,
   output logic                       acc_res_v,
   output logic                       acc_ovf,
   output logic                       busy
);

   localparam int TW = 37;
   localparam logic signed [ACC_W:0] MaxVal = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MinVal = {2'b11, {(ACC_W-1){1'b0}}};

   typedef enum logic {IDLE, ACCUM} state_t;

   logic signed [TW-1:0] lane_q [NUM_LANE];
   logic signed [TW-1:0] s1_q [13];
   logic signed [TW-1:0] s2_q [7];
   logic signed [TW-1:0] s3_q [4];
   logic signed [TW-1:0] s4_q [2];
   logic signed [TW-1:0] s5_q;
   logic [5:0]           stageV_q;

   state_t               state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]           beatCnt_q, beatCnt_d;
   logic [ACC_W-1:0]     res_q, res_d;
   logic                 resV_q, resV_d;
   logic                 ovf_q, ovf_d;

   logic signed [ACC_W:0]   baseExt, sumExt, nextFull;
   logic signed [ACC_W-1:0] satVal;
   logic                    satHit;
   logic [7:0]              cntInc;

   // Valid chain: stage 0 is the input capture register, stage 5 is the tree sum.
   always_ff @(posedge clk) begin
      if (rst || start) stageV_q <= '0;
      else              stageV_q <= {stageV_q[4:0], mult_res_v};
   end

   // Tree data needs no reset; the valid chain alone qualifies it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANE; i++)
         lane_q[i] <= TW'($signed(mult_res[i*PROD_W +: PROD_W]));
      for (int i = 0; i < 12; i++) s1_q[i] <= lane_q[2*i] + lane_q[2*i+1];
      s1_q[12] <= lane_q[24];
      for (int i = 0; i < 6; i++) s2_q[i] <= s1_q[2*i] + s1_q[2*i+1];
      s2_q[6] <= s1_q[12];
      for (int i = 0; i < 3; i++) s3_q[i] <= s2_q[2*i] + s2_q[2*i+1];
      s3_q[3] <= s2_q[6];
      s4_q[0] <= s3_q[0] + s3_q[1];
      s4_q[1] <= s3_q[2] + s3_q[3];
      s5_q    <= s4_q[0] + s4_q[1];
   end

   // From IDLE the first beat starts from zero, so back-to-back groups need no bubble.
   always_comb begin
      baseExt  = (state_q == ACCUM) ? {acc_q[ACC_W-1], acc_q} : '0;
      sumExt   = (ACC_W+1)'(s5_q);
      nextFull = baseExt + sumExt;
      satHit   = 1'b0;
      satVal   = nextFull[ACC_W-1:0];
      if (nextFull > MaxVal) begin
         satVal = MaxVal[ACC_W-1:0];
         satHit = 1'b1;
      end else if (nextFull < MinVal) begin
         satVal = MinVal[ACC_W-1:0];
         satHit = 1'b1;
      end
      cntInc = ((state_q == ACCUM) ? beatCnt_q : 8'd0) + 8'd1;

      state_d   = state_q;
      acc_d     = acc_q;
      beatCnt_d = beatCnt_q;
      res_d     = res_q;
      resV_d    = 1'b0;
      ovf_d     = ovf_q;
      if (stageV_q[5]) begin
         if (satHit) ovf_d = 1'b1;
         if (cntInc == 8'(ACC_LEN)) begin
            res_d     = satVal;
            resV_d    = 1'b1;
            acc_d     = '0;
            beatCnt_d = '0;
            state_d   = IDLE;
         end else begin
            acc_d     = satVal;
            beatCnt_d = cntInc;
            state_d   = ACCUM;
         end
      end
   end

   // start clears everything except the last published result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         beatCnt_q <= '0;
         res_q     <= '0;
         resV_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (start) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         beatCnt_q <= '0;
         resV_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         beatCnt_q <= beatCnt_d;
         res_q     <= res_d;
         resV_q    <= resV_d;
         ovf_q     <= ovf_d;
      end
   end

   assign acc_res   = res_q;
   assign acc_res_v = resV_q;
   assign acc_ovf   = ovf_q;
   assign busy      = (state_q == ACCUM) | (|stageV_q);

endmodule

// File: tb/tb_conv1_layer1_dense_accum.sv
// Directed bench for conv1_layer1_dense_accum: three instances (ACC_LEN 8, ACC_LEN 1, and a
// narrow 40-bit/255-beat saturating one) share stimulus; pulses are logged with edge stamps.
module tb_conv1_layer1_dense_accum;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [799:0] multRes = '0;
   logic         multResV = 1'b0;

   logic [47:0] accRes8, accRes1;
   logic [39:0] accResS;
   logic        accResV8, accOvf8, busy8;
   logic        accResV1, accOvf1, busy1;
   logic        accResVS, accOvfS, busyS;

   int cyc = 0;
   int nChecks = 0;
   int nErrors = 0;

   typedef struct {int cyc; longint val;} pulse_t;
   pulse_t q8[$];
   pulse_t q1[$];
   pulse_t qS[$];

   typedef struct {int others; int l0; int l24; longint expSum;} vec_t;
   vec_t vecs[6];
   int   vecEdge[6];

   conv1_layer1_dense_accum dut (
      .clk(clk), .rst(rst), .start(start), .mult_res(multRes), .mult_res_v(multResV),
      .acc_res(accRes8), .acc_res_v(accResV8), .acc_ovf(accOvf8), .busy(busy8));

   conv1_layer1_dense_accum #(.ACC_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .mult_res(multRes), .mult_res_v(multResV),
      .acc_res(accRes1), .acc_res_v(accResV1), .acc_ovf(accOvf1), .busy(busy1));

   conv1_layer1_dense_accum #(.ACC_W(40), .ACC_LEN(255)) dutS (
      .clk(clk), .rst(rst), .start(start), .mult_res(multRes), .mult_res_v(multResV),
      .acc_res(accResS), .acc_res_v(accResVS), .acc_ovf(accOvfS), .busy(busyS));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulses are logged mid-cycle, stamped with the edge that produced them.
   always @(negedge clk) begin
      if (accResV8) q8.push_back('{cyc, longint'($signed(accRes8))});
      if (accResV1) q1.push_back('{cyc, longint'($signed(accRes1))});
      if (accResVS) qS.push_back('{cyc, longint'($signed(accResS))});
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic setLanes(input int others, input int l0, input int l24);
      for (int i = 0; i < 25; i++) multRes[i*32 +: 32] = others;
      multRes[31:0]    = l0;
      multRes[799:768] = l24;
   endtask

   // One beat; the returned edge number is the edge that samples it.
   task automatic applyStimulus(input int others, input int l0, input int l24, output int edgeNo);
      setLanes(others, l0, l24);
      multResV = 1'b1;
      edgeNo = cyc + 1;
      @(posedge clk);
      #1;
      multResV = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      int e, lastEdge, e7;
      vecs[0] = '{0, -5, 3, -2};
      vecs[1] = '{1, 1, 1, 25};
      vecs[2] = '{-1, -1, -1, -25};
      vecs[3] = '{2, -100, 7, -47};
      vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'sd53687091175};
      vecs[5] = '{32'h80000000, 32'h80000000, 32'h80000000, -64'sd53687091200};

      // Reset must win over start and a valid beat in the same cycle.
      #1;
      setLanes(9, 9, 9);
      multResV = 1'b1;
      start = 1'b1;
      doReset();
      multResV = 1'b0;
      start = 1'b0;
      checkOutput("reset acc_res", accRes8, 0);
      checkOutput("reset acc_res_v", accResV8, 0);
      checkOutput("reset acc_ovf", accOvf8, 0);
      idle(1);
      checkOutput("reset busy", busy8, 0);
      q8.delete(); q1.delete(); qS.delete();

      // Eight back-to-back beats of all ones.
      for (int k = 0; k < 8; k++) applyStimulus(1, 1, 1, lastEdge);
      checkOutput("t1 busy mid-group", busy8, 1);
      idle(10);
      checkOutput("t1 pulse count", q8.size(), 1);
      checkOutput("t1 acc_res", (q8.size() > 0) ? q8[0].val : -1, 200);
      checkOutput("t1 latency", (q8.size() > 0) ? q8[0].cyc : -1, lastEdge + 6);
      checkOutput("t1 busy drained", busy8, 0);
      checkOutput("t1 ACC_LEN=1 pulses", q1.size(), 8);

      // Table: ACC_LEN=1 instance emits each beat's tree sum 6 edges later.
      doReset();
      q1.delete();
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i].others, vecs[i].l0, vecs[i].l24, vecEdge[i]);
      idle(10);
      checkOutput("t2 pulse count", q1.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < q1.size()) begin
            checkOutput($sformatf("t2 vec%0d sum", i), q1[i].val, vecs[i].expSum);
            checkOutput($sformatf("t2 vec%0d latency", i), q1[i].cyc, vecEdge[i] + 6);
         end
      end

      // Continuous 16-beat stream, lanes = beat index.
      doReset();
      q8.delete();
      for (int k = 0; k < 16; k++) begin
         applyStimulus(k, k, k, e);
         if (k == 7) e7 = e;
         if (k == 15) lastEdge = e;
      end
      idle(10);
      checkOutput("t3 pulse count", q8.size(), 2);
      checkOutput("t3 first sum", (q8.size() > 0) ? q8[0].val : -1, 700);
      checkOutput("t3 second sum", (q8.size() > 1) ? q8[1].val : -1, 2300);
      checkOutput("t3 first latency", (q8.size() > 0) ? q8[0].cyc : -1, e7 + 6);
      checkOutput("t3 second latency", (q8.size() > 1) ? q8[1].cyc : -1, lastEdge + 6);

      // Saturation on the 40-bit, 255-beat instance.
      doReset();
      qS.delete();
      for (int k = 0; k < 255; k++) applyStimulus(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, e);
      idle(10);
      checkOutput("t4 sat pulse count", qS.size(), 1);
      checkOutput("t4 sat value", (qS.size() > 0) ? qS[0].val : -1, 64'sd549755813887);
      checkOutput("t4 ovf set", accOvfS, 1);
      checkOutput("t4 wide instance no ovf", accOvf8, 0);
      for (int k = 0; k < 255; k++) applyStimulus(1, 1, 1, e);
      idle(10);
      checkOutput("t4 normal group sum", (qS.size() > 1) ? qS[1].val : -1, 6375);
      checkOutput("t4 ovf sticky", accOvfS, 1);
      pulseStart();
      checkOutput("t4 ovf cleared by start", accOvfS, 0);
      checkOutput("t4 acc_res held over start", longint'($signed(accResS)), 6375);

      // start while beats are in flight; a beat coinciding with start is dropped too.
      doReset();
      q8.delete();
      for (int k = 0; k < 3; k++) applyStimulus(1, 1, 1, e);
      idle(1);
      setLanes(1000, 1000, 1000);
      multResV = 1'b1;
      pulseStart();
      multResV = 1'b0;
      idle(10);
      checkOutput("t5 no pulse after start", q8.size(), 0);
      checkOutput("t5 busy after start", busy8, 0);
      for (int k = 0; k < 8; k++) applyStimulus(1, 1, 1, e);
      idle(10);
      checkOutput("t5 clean group", (q8.size() > 0) ? q8[0].val : -1, 200);

      // rst mid-group with idle gaps, then a gapped full group.
      applyStimulus(7, 7, 7, e);
      idle(3);
      applyStimulus(7, 7, 7, e);
      idle(3);
      applyStimulus(7, 7, 7, e);
      idle(2);
      doReset();
      checkOutput("t6 acc_res after rst", accRes8, 0);
      checkOutput("t6 acc_res_v after rst", accResV8, 0);
      checkOutput("t6 acc_ovf after rst", accOvf8, 0);
      checkOutput("t6 busy after rst", busy8, 0);
      checkOutput("t6 wide acc_res after rst", accResS, 0);
      q8.delete();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(2, 2, 2, e);
         idle(3);
      end
      idle(10);
      checkOutput("t6 pulse count", q8.size(), 1);
      checkOutput("t6 gapped group", (q8.size() > 0) ? q8[0].val : -1, 400);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
